// File: rtl/pong_pkg.sv
// Shared definitions for the pong match controller: state codes, index
// widths and the small combinational helpers used by the sequencer.
package pong_pkg;

  localparam int STATE_WIDTH = 3;
  localparam int PIDX_WIDTH  = 2;
  localparam int MAX_PLAYERS = 4;

  typedef logic [STATE_WIDTH-1:0] state_t;
  typedef logic [PIDX_WIDTH-1:0]  pidx_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_SERVE  = 3'd1;
  localparam state_t ST_PLAY   = 3'd2;
  localparam state_t ST_POINT  = 3'd3;
  localparam state_t ST_PAUSED = 3'd4;
  localparam state_t ST_OVER   = 3'd5;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic pidx_t lowest_set(input logic [MAX_PLAYERS-1:0] mask);
    pidx_t idx;
    idx = '0;
    for (int i = MAX_PLAYERS - 1; i >= 0; i--) begin
      if (mask[i]) idx = pidx_t'(i);
    end
    return idx;
  endfunction

  // Number of set bits in a player mask.
  function automatic logic [2:0] popcount4(input logic [MAX_PLAYERS-1:0] mask);
    logic [2:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_PLAYERS; i++) begin
      cnt = cnt + 3'(mask[i]);
    end
    return cnt;
  endfunction

  // First alive player strictly after cur, searching upward and wrapping
  // within num players. Returns cur unchanged if nobody else is alive.
  function automatic pidx_t next_alive(input logic [MAX_PLAYERS-1:0] alive_mask,
                                       input pidx_t cur, input int num);
    pidx_t res;
    logic  found;
    int    idx;
    res   = cur;
    found = 1'b0;
    for (int k = 1; k <= MAX_PLAYERS; k++) begin
      idx = (int'(cur) + k) % num;
      if (!found && k <= num && alive_mask[idx[1:0]]) begin
        res   = pidx_t'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pong_match_ctrl_if.sv
// Bundle of the match controller's game-side signals. The master side
// (collision logic, button synchronizers) drives the events, the slave
// side (the controller) drives the match status back to the painters.
interface pong_match_ctrl_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int LIVES_WIDTH = 3
);
  import pong_pkg::*;

  logic                               en;
  logic                               frame_pulse;
  logic [NUM_PLAYERS-1:0]             btn_action;
  logic                               ball_out;
  logic [PIDX_WIDTH-1:0]              out_player;
  logic                               paddle_hit;
  logic [STATE_WIDTH-1:0]             state;
  logic [NUM_PLAYERS*LIVES_WIDTH-1:0] lives;
  logic [NUM_PLAYERS-1:0]             alive;
  logic [PIDX_WIDTH-1:0]              server;
  logic [3:0]                         speed;
  logic                               ball_reset;
  logic                               ball_release;
  logic [PIDX_WIDTH-1:0]              winner;
  logic                               winner_valid;

  modport master (
    output en, frame_pulse, btn_action, ball_out, out_player, paddle_hit,
    input  state, lives, alive, server, speed, ball_reset, ball_release,
           winner, winner_valid
  );

  modport slave (
    input  en, frame_pulse, btn_action, ball_out, out_player, paddle_hit,
    output state, lives, alive, server, speed, ball_reset, ball_release,
           winner, winner_valid
  );
endinterface

// File: rtl/pong_edge_detect.sv
// Per-bit rising-edge detector for already-synchronized level inputs.
// The history register holds while disabled so a press made during a
// disabled stretch is still seen once the block is enabled again.
module pong_edge_detect #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] prev_reg;

  // Track the previous sampled level of every bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_reg <= '0;
    end else if (en) begin
      prev_reg <= din;
    end
  end

  assign rise = din & ~prev_reg;

endmodule

// File: rtl/pong_match_ctrl.sv
// N-player pong match sequencer: owns lives, serve countdown, pause,
// ball speed ramp and winner detection, stepping on frame pulses and
// collision events. All outputs come straight from registers.
module pong_match_ctrl #(
  parameter int NUM_PLAYERS      = 2,
  parameter int LIVES_WIDTH      = 3,
  parameter int START_LIVES      = 3,
  parameter int SERVE_FRAMES     = 60,
  parameter int HITS_PER_SPEEDUP = 4,
  parameter int INIT_SPEED       = 2,
  parameter int MAX_SPEED        = 7
) (
  input  logic              clk,
  input  logic              rst,
  pong_match_ctrl_if.slave  bus
);
  import pong_pkg::*;

  localparam int SC_W = $clog2(SERVE_FRAMES + 1);
  localparam int HC_W = $clog2(HITS_PER_SPEEDUP + 1);

  typedef logic [LIVES_WIDTH-1:0] lives_t;

  localparam lives_t          LIVES_LOAD = lives_t'(START_LIVES);
  localparam lives_t          LIFE_ONE   = lives_t'(1);
  localparam logic [SC_W-1:0] SERVE_LOAD = SC_W'(SERVE_FRAMES);
  localparam logic [HC_W-1:0] HIT_LAST   = HC_W'(HITS_PER_SPEEDUP - 1);
  localparam logic [3:0]      SPEED_INIT = 4'(INIT_SPEED);
  localparam logic [3:0]      SPEED_MAX  = 4'(MAX_SPEED);

  state_t                 state_reg, state_next;
  lives_t                 lives_reg [NUM_PLAYERS];
  lives_t                 lives_next [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] alive_reg, alive_next;
  pidx_t                  server_reg, server_next;
  pidx_t                  winner_reg, winner_next;
  logic                   winner_valid_reg, winner_valid_next;
  logic [3:0]             speed_reg, speed_next;
  logic [SC_W-1:0]        serve_cnt_reg, serve_cnt_next;
  logic [HC_W-1:0]        hit_cnt_reg, hit_cnt_next;
  logic                   ball_reset_reg, ball_reset_next;
  logic                   ball_release_reg, ball_release_next;

  logic [NUM_PLAYERS-1:0] press;
  logic [MAX_PLAYERS-1:0] press4;
  logic [MAX_PLAYERS-1:0] alive4;
  logic                   any_press;
  logic                   server_press;
  logic                   out_alive;

  pong_edge_detect #(
    .WIDTH (NUM_PLAYERS)
  ) u_btn_edge (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.en),
    .din  (bus.btn_action),
    .rise (press)
  );

  assign any_press = |press;

  // Widen the per-player masks to the package's fixed four-player view,
  // and pack the lives counters onto the output bus.
  for (genvar gi = 0; gi < MAX_PLAYERS; gi++) begin : g_mask
    if (gi < NUM_PLAYERS) begin : g_used
      assign press4[gi] = press[gi];
      assign alive4[gi] = alive_reg[gi];
      assign bus.lives[gi*LIVES_WIDTH +: LIVES_WIDTH] = lives_reg[gi];
    end else begin : g_unused
      assign press4[gi] = 1'b0;
      assign alive4[gi] = 1'b0;
    end
  end

  // Decode "the server pressed" and "the out-of-bounds player is alive";
  // an out-of-range out_player never matches and so reads as dead.
  always_comb begin
    server_press = 1'b0;
    out_alive    = 1'b0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (server_reg == pidx_t'(i) && press[i]) server_press = 1'b1;
      if (bus.out_player == pidx_t'(i) && alive_reg[i]) out_alive = 1'b1;
    end
  end

  // Match sequencer: everything holds and pulses drop while disabled.
  always_comb begin
    state_next        = state_reg;
    server_next       = server_reg;
    winner_next       = winner_reg;
    winner_valid_next = winner_valid_reg;
    speed_next        = speed_reg;
    serve_cnt_next    = serve_cnt_reg;
    hit_cnt_next      = hit_cnt_reg;
    ball_reset_next   = 1'b0;
    ball_release_next = 1'b0;
    for (int i = 0; i < NUM_PLAYERS; i++) lives_next[i] = lives_reg[i];

    if (bus.en) begin
      case (state_reg)
        ST_IDLE: begin
          if (any_press) begin
            for (int i = 0; i < NUM_PLAYERS; i++) lives_next[i] = LIVES_LOAD;
            server_next     = lowest_set(press4);
            ball_reset_next = 1'b1;
            serve_cnt_next  = SERVE_LOAD;
            state_next      = ST_SERVE;
          end
        end

        ST_SERVE: begin
          // The server may cut the countdown short with a press.
          if (server_press || (bus.frame_pulse && serve_cnt_reg == SC_W'(1))) begin
            speed_next        = SPEED_INIT;
            hit_cnt_next      = '0;
            ball_release_next = 1'b1;
            state_next        = ST_PLAY;
          end else if (bus.frame_pulse) begin
            serve_cnt_next = serve_cnt_reg - SC_W'(1);
          end
        end

        ST_PLAY: begin
          // A scored point outranks a same-cycle hit or pause press.
          if (bus.ball_out && out_alive) begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
              if (bus.out_player == pidx_t'(i)) lives_next[i] = lives_reg[i] - LIFE_ONE;
            end
            server_next = bus.out_player;
            state_next  = ST_POINT;
          end else begin
            if (bus.paddle_hit) begin
              if (hit_cnt_reg == HIT_LAST) begin
                hit_cnt_next = '0;
                speed_next   = (speed_reg >= SPEED_MAX) ? SPEED_MAX : speed_reg + 4'd1;
              end else begin
                hit_cnt_next = hit_cnt_reg + HC_W'(1);
              end
            end
            if (any_press) state_next = ST_PAUSED;
          end
        end

        ST_POINT: begin
          // alive_reg already reflects the decrement made on entry.
          if (!alive4[server_reg]) server_next = next_alive(alive4, server_reg, NUM_PLAYERS);
          if (popcount4(alive4) == 3'd1) begin
            winner_next       = lowest_set(alive4);
            winner_valid_next = 1'b1;
            state_next        = ST_OVER;
          end else begin
            ball_reset_next = 1'b1;
            serve_cnt_next  = SERVE_LOAD;
            state_next      = ST_SERVE;
          end
        end

        ST_PAUSED: begin
          if (any_press) state_next = ST_PLAY;
        end

        ST_OVER: begin
          if (any_press) begin
            winner_valid_next = 1'b0;
            state_next        = ST_IDLE;
          end
        end

        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Alive flags are registered alongside the lives they summarise.
  always_comb begin
    alive_next = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) alive_next[i] = |lives_next[i];
  end

  // State register; reset takes priority over the enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      for (int i = 0; i < NUM_PLAYERS; i++) lives_reg[i] <= '0;
      alive_reg        <= '0;
      server_reg       <= '0;
      winner_reg       <= '0;
      winner_valid_reg <= 1'b0;
      speed_reg        <= '0;
      serve_cnt_reg    <= '0;
      hit_cnt_reg      <= '0;
      ball_reset_reg   <= 1'b0;
      ball_release_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      for (int i = 0; i < NUM_PLAYERS; i++) lives_reg[i] <= lives_next[i];
      alive_reg        <= alive_next;
      server_reg       <= server_next;
      winner_reg       <= winner_next;
      winner_valid_reg <= winner_valid_next;
      speed_reg        <= speed_next;
      serve_cnt_reg    <= serve_cnt_next;
      hit_cnt_reg      <= hit_cnt_next;
      ball_reset_reg   <= ball_reset_next;
      ball_release_reg <= ball_release_next;
    end
  end

  assign bus.state        = state_reg;
  assign bus.alive        = alive_reg;
  assign bus.server       = server_reg;
  assign bus.speed        = speed_reg;
  assign bus.ball_reset   = ball_reset_reg;
  assign bus.ball_release = ball_release_reg;
  assign bus.winner       = winner_reg;
  assign bus.winner_valid = winner_valid_reg;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: a two-player and a four-player instance run
// side by side on shared stimulus, each checked every cycle against a
// rule-level model of the match, followed by a randomized stretch.
module tb_pong_match_ctrl;

  localparam int LW    = 3;
  localparam int START = 3;
  localparam int SF    = 60;
  localparam int HPS   = 4;
  localparam int INITS = 2;
  localparam int MAXS  = 7;

  localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_POINT = 3, S_PAUSED = 4, S_OVER = 5;

  logic clk;
  logic rst;

  pong_match_ctrl_if #(.NUM_PLAYERS(2), .LIVES_WIDTH(LW)) if2 ();
  pong_match_ctrl_if #(.NUM_PLAYERS(4), .LIVES_WIDTH(LW)) if4 ();

  pong_match_ctrl #(
    .NUM_PLAYERS(2), .LIVES_WIDTH(LW), .START_LIVES(START), .SERVE_FRAMES(SF),
    .HITS_PER_SPEEDUP(HPS), .INIT_SPEED(INITS), .MAX_SPEED(MAXS)
  ) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

  pong_match_ctrl #(
    .NUM_PLAYERS(4), .LIVES_WIDTH(LW), .START_LIVES(START), .SERVE_FRAMES(SF),
    .HITS_PER_SPEEDUP(HPS), .INIT_SPEED(INITS), .MAX_SPEED(MAXS)
  ) u_dut4 (.clk(clk), .rst(rst), .bus(if4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, index 0 = two-player match, 1 = four-player.
  int m_st[2];
  int m_lives[2][4];
  int m_server[2];
  int m_speed[2];
  int m_hits[2];
  int m_frames[2];
  int m_winner[2];
  bit m_wv[2];
  bit m_brst[2];
  bit m_brel[2];
  bit m_prev[2][4];

  task automatic chk(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // One clock of the match rules for a match of num players.
  task automatic model_step(input int k, input int num, input bit r, input bit e, input bit fp,
                            input bit [3:0] b, input bit bo, input int op, input bit ph);
    bit pr[4];
    bit anyp;
    int lowp;
    int na;
    int first;
    bit found;
    int c;
    if (r) begin
      m_st[k] = S_IDLE;
      for (int i = 0; i < 4; i++) begin m_lives[k][i] = 0; m_prev[k][i] = 0; end
      m_server[k] = 0; m_speed[k] = 0; m_hits[k] = 0; m_frames[k] = 0;
      m_winner[k] = 0; m_wv[k] = 0; m_brst[k] = 0; m_brel[k] = 0;
      return;
    end
    m_brst[k] = 0;
    m_brel[k] = 0;
    if (!e) return;
    anyp = 0;
    lowp = -1;
    for (int i = 0; i < 4; i++) begin
      pr[i] = 0;
      if (i < num) begin
        pr[i] = b[i] && !m_prev[k][i];
        m_prev[k][i] = b[i];
        if (pr[i]) begin
          anyp = 1;
          if (lowp < 0) lowp = i;
        end
      end
    end
    case (m_st[k])
      S_IDLE: if (anyp) begin
        for (int i = 0; i < num; i++) m_lives[k][i] = START;
        m_server[k] = lowp;
        m_brst[k]   = 1;
        m_frames[k] = 0;
        m_st[k]     = S_SERVE;
      end
      S_SERVE: begin
        if (fp) m_frames[k]++;
        if (pr[m_server[k]] || m_frames[k] == SF) begin
          m_speed[k] = INITS;
          m_hits[k]  = 0;
          m_brel[k]  = 1;
          m_st[k]    = S_PLAY;
        end
      end
      S_PLAY: begin
        if (bo && op < num && m_lives[k][op] > 0) begin
          m_lives[k][op]--;
          m_server[k] = op;
          m_st[k]     = S_POINT;
        end else begin
          if (ph) begin
            m_hits[k]++;
            if (m_hits[k] == HPS) begin
              m_hits[k]  = 0;
              m_speed[k] = (m_speed[k] + 1 > MAXS) ? MAXS : m_speed[k] + 1;
            end
          end
          if (anyp) m_st[k] = S_PAUSED;
        end
      end
      S_POINT: begin
        na = 0;
        first = -1;
        for (int i = 0; i < num; i++) begin
          if (m_lives[k][i] > 0) begin
            na++;
            if (first < 0) first = i;
          end
        end
        if (m_lives[k][m_server[k]] == 0) begin
          found = 0;
          for (int d = 1; d <= num; d++) begin
            c = (m_server[k] + d) % num;
            if (!found && m_lives[k][c] > 0) begin
              m_server[k] = c;
              found = 1;
            end
          end
        end
        if (na == 1) begin
          m_winner[k] = first;
          m_wv[k]     = 1;
          m_st[k]     = S_OVER;
        end else begin
          m_brst[k]   = 1;
          m_frames[k] = 0;
          m_st[k]     = S_SERVE;
        end
      end
      S_PAUSED: if (anyp) m_st[k] = S_PLAY;
      S_OVER: if (anyp) begin
        m_wv[k] = 0;
        m_st[k] = S_IDLE;
      end
      default: m_st[k] = S_IDLE;
    endcase
  endtask

  task automatic check_dut(input int k, input int num, input string p, input int st, input int lv,
                           input int al, input int sv, input int sp, input int br, input int bl,
                           input int wn, input int wv);
    int exp_lv;
    int exp_al;
    exp_lv = 0;
    exp_al = 0;
    for (int i = 0; i < num; i++) begin
      exp_lv = exp_lv | (m_lives[k][i] << (i * LW));
      if (m_lives[k][i] > 0) exp_al = exp_al | (1 << i);
    end
    chk({p, ".state"}, st, m_st[k]);
    chk({p, ".lives"}, lv, exp_lv);
    chk({p, ".alive"}, al, exp_al);
    chk({p, ".server"}, sv, m_server[k]);
    chk({p, ".speed"}, sp, m_speed[k]);
    chk({p, ".ball_reset"}, br, int'(m_brst[k]));
    chk({p, ".ball_release"}, bl, int'(m_brel[k]));
    chk({p, ".winner"}, wn, m_winner[k]);
    chk({p, ".winner_valid"}, wv, int'(m_wv[k]));
  endtask

  // Drive one cycle of inputs, step both models and compare after the edge.
  task automatic tick(input bit r, input bit e, input bit fp, input logic [3:0] b,
                      input bit bo, input logic [1:0] op, input bit ph);
    rst = r;
    if2.en = e;          if4.en = e;
    if2.frame_pulse = fp; if4.frame_pulse = fp;
    if2.btn_action = b[1:0]; if4.btn_action = b;
    if2.ball_out = bo;   if4.ball_out = bo;
    if2.out_player = op; if4.out_player = op;
    if2.paddle_hit = ph; if4.paddle_hit = ph;
    @(posedge clk);
    model_step(0, 2, r, e, fp, b, bo, int'(op), ph);
    model_step(1, 4, r, e, fp, b, bo, int'(op), ph);
    #1;
    check_dut(0, 2, "d2", int'(if2.state), int'(if2.lives), int'(if2.alive), int'(if2.server),
              int'(if2.speed), int'(if2.ball_reset), int'(if2.ball_release), int'(if2.winner),
              int'(if2.winner_valid));
    check_dut(1, 4, "d4", int'(if4.state), int'(if4.lives), int'(if4.alive), int'(if4.server),
              int'(if4.speed), int'(if4.ball_reset), int'(if4.ball_release), int'(if4.winner),
              int'(if4.winner_valid));
  endtask

  task automatic idle();
    tick(0, 1, 0, 4'h0, 0, 2'd0, 0);
  endtask

  // Every server presses (ends SERVE early), then all buttons released.
  task automatic serve_skip();
    tick(0, 1, 0, 4'hF, 0, 2'd0, 0);
    tick(0, 1, 0, 4'h0, 0, 2'd0, 0);
  endtask

  logic [3:0] btn;

  initial begin
    rst = 1'b1;
    btn = 4'h0;
    tick(1, 1, 0, 4'h0, 0, 2'd0, 0);
    tick(1, 1, 0, 4'h0, 0, 2'd0, 0);
    chk("reset.state", int'(if2.state), S_IDLE);
    chk("reset.lives", int'(if4.lives), 0);

    // Start by player 1: lives loaded, server 1, ball recentred.
    tick(0, 1, 0, 4'b0010, 0, 2'd0, 0);
    chk("start.state", int'(if2.state), S_SERVE);
    chk("start.lives2", int'(if2.lives), 3 + (3 << 3));
    chk("start.lives4", int'(if4.lives), 3 * (1 + 8 + 64 + 512));
    chk("start.server", int'(if2.server), 1);
    chk("start.ball_reset", int'(if2.ball_reset), 1);
    idle();
    for (int i = 1; i <= SF; i++) begin
      tick(0, 1, 1, 4'h0, 0, 2'd0, 0);
      chk("serve.release", int'(if2.ball_release), int'(i == SF));
      if (i < SF) idle();
    end
    chk("serve.play", int'(if4.state), S_PLAY);

    // Speed ramp and saturation.
    for (int i = 0; i < 8; i++) tick(0, 1, 0, 4'h0, 0, 2'd0, 1);
    chk("ramp.speed4", int'(if2.speed), 4);
    for (int i = 0; i < 40; i++) tick(0, 1, 0, 4'h0, 0, 2'd0, 1);
    chk("ramp.sat", int'(if4.speed), 7);

    // Three points against player 0 ends the two-player match.
    for (int n = 0; n < 3; n++) begin
      tick(0, 1, 0, 4'h0, 1, 2'd0, 0);
      idle();
      if (n < 2) serve_skip();
    end
    chk("over.state", int'(if2.state), S_OVER);
    chk("over.winner", int'(if2.winner), 1);
    chk("over.valid", int'(if2.winner_valid), 1);
    chk("over.lives0", int'(if2.lives[2:0]), 0);
    chk("over.server4", int'(if4.server), 1);

    // Kill player 2 while serving in the four-player match.
    serve_skip();
    for (int n = 0; n < 3; n++) begin
      tick(0, 1, 0, 4'h0, 1, 2'd2, 0);
      idle();
      if (n < 2) serve_skip();
    end
    chk("dead.server", int'(if4.server), 3);
    serve_skip();
    tick(0, 1, 0, 4'h0, 1, 2'd2, 0);
    chk("dead.ignored_state", int'(if4.state), S_PLAY);
    chk("dead.ignored_lives", int'(if4.lives[8:6]), 0);

    // Pause freezes the match.
    tick(0, 1, 0, 4'hF, 0, 2'd0, 0);
    idle();
    chk("pause.state", int'(if4.state), S_PAUSED);
    for (int i = 0; i < 5; i++) tick(0, 1, 1, 4'h0, 1, 2'd1, 1);
    chk("pause.hold", int'(if4.state), S_PAUSED);
    chk("pause.lives1", int'(if4.lives[5:3]), 3);
    tick(0, 1, 0, 4'hF, 0, 2'd0, 0);
    chk("resume.state", int'(if4.state), S_PLAY);
    idle();

    // Same-cycle out and hit; then reset during SERVE.
    tick(0, 1, 0, 4'h0, 1, 2'd3, 1);
    chk("both.lives3", int'(if4.lives[11:9]), 2);
    idle();
    chk("both.serve", int'(if4.state), S_SERVE);
    tick(1, 1, 0, 4'h0, 0, 2'd0, 0);
    chk("midrst.state", int'(if4.state), S_IDLE);
    chk("midrst.lives", int'(if4.lives), 0);
    chk("midrst.speed", int'(if4.speed), 0);
    idle();

    // Randomized play against the model.
    for (int c = 0; c < 6000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 7) == 0) btn[i] = ~btn[i];
      end
      tick(($urandom_range(0, 599) == 0), ($urandom_range(0, 15) != 0),
           ($urandom_range(0, 2) == 0), btn, ($urandom_range(0, 9) == 0),
           2'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pong_match_ctrl.md
# pong_match_ctrl

Parametrised match controller for the pong game: generalises the fixed two-player, two-bit-lives, one-bit game state of the current top level into an N-player match sequencer. It owns lives, serve countdown, pause, ball speed ramp and winner detection. It sits between the button synchronizers, the collision/out-of-bounds logic and the ball/paddle/lives painters, and advances on `frame_pulse`.

## Interface

Parameters:
- NUM_PLAYERS, 2: players in the match, 2..4.
- LIVES_WIDTH, 3: bits per lives counter.
- START_LIVES, 3: lives loaded at match start; must be ≥1 and < 2^LIVES_WIDTH.
- SERVE_FRAMES, 60: frames between a serve request and ball release; must be ≥1.
- HITS_PER_SPEEDUP, 4: paddle hits per speed increment.
- INIT_SPEED, 2: speed after each serve.
- MAX_SPEED, 7: speed saturation value, ≤15.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  clock enable; when low all state holds and all pulse outputs are 0.
- frame_pulse  in  1  one-cycle pulse per VGA frame.
- btn_action  in  NUM_PLAYERS  synchronized action buttons, level.
- ball_out  in  1  one-cycle pulse: the ball left the field.
- out_player  in  2  index of the player whose goal was crossed; valid with ball_out.
- paddle_hit  in  1  one-cycle pulse per paddle collision.
- state  out  3  current FSM state code.
- lives  out  NUM_PLAYERS*LIVES_WIDTH  packed lives, player 0 in LSBs.
- alive  out  NUM_PLAYERS  bit i set while lives of player i are nonzero.
- server  out  2  player who serves next.
- speed  out  4  ball speed magnitude for the ball mover.
- ball_reset  out  1  one-cycle pulse: recentre the ball.
- ball_release  out  1  one-cycle pulse: start ball motion.
- winner  out  2  winning player index; valid while winner_valid.
- winner_valid  out  1  high in GAME_OVER.

## Operation

- States: IDLE=0, SERVE=1, PLAY=2, POINT=3, PAUSED=4, OVER=5.
- Button edges: a per-player registered copy of btn_action; press = rising edge. any_press = OR of edges.
- IDLE: any_press → load all lives to START_LIVES, server=pressing player (lowest index if several), pulse ball_reset, load serve counter, go SERVE.
- SERVE: counter decrements on frame_pulse; at counter 1 and frame_pulse → speed=INIT_SPEED, hit count cleared, pulse ball_release, go PLAY. A press by the server skips the remaining wait (release on that cycle).
- PLAY: paddle_hit increments hit count; on reaching HITS_PER_SPEEDUP, clear count and speed=min(speed+1, MAX_SPEED). ball_out with alive[out_player] → decrement that player's lives (never below 0), server=out_player, go POINT. ball_out for a dead or out-of-range player is ignored. Press by any player → PAUSED.
- POINT (one cycle): if popcount(alive after decrement) == 1 → winner=that player, go OVER; else pulse ball_reset, load serve counter, go SERVE. If server is dead, server = next alive index upward, wrapping.
- PAUSED: counters, lives and speed frozen; ball_release/ball_reset not issued; any press → PLAY. ball_out and paddle_hit ignored.
- OVER: winner_valid=1; any press → IDLE (lives stay until next start).
- Simultaneous ball_out and paddle_hit in PLAY: ball_out wins, hit ignored. Simultaneous press and ball_out in PLAY: ball_out wins.

## Timing

- All outputs registered; reset values: state=IDLE, lives all 0, alive=0, server=0, speed=0, ball_reset=0, ball_release=0, winner=0, winner_valid=0.
- Input event at cycle n → state/lives/pulse outputs change at n+1.
- Serve latency: exactly SERVE_FRAMES frame_pulses after entering SERVE.
- Reset mid-match returns to IDLE next edge regardless of state; rst dominates en.
- speed arithmetic 4-bit saturating; hit count width clog2(HITS_PER_SPEEDUP+1).

## Structure

- Shared package pong_pkg: state enum codes, STATE_WIDTH=3, player index width 2.
- Sub-module: pong_edge_detect (per-bit rising-edge register, width parameter), instantiated once over btn_action.
- Next-alive-server search as a combinational function in the package.

## Test plan

- Reset, press btn_action[1] → next cycle state=SERVE, lives all 3, server=1, ball_reset pulse; ball_release exactly 60 frame_pulses later.
- PLAY, 8 paddle_hit pulses with INIT_SPEED=2 → speed 4; 40 more → saturates at 7.
- NUM_PLAYERS=2, three ball_out on player 0 → after third, state=OVER, winner=1, winner_valid=1, lives[0]=0.
- NUM_PLAYERS=4, kill player 2 while server=2 → server becomes 3; ball_out with out_player=2 thereafter ignored.
- PLAY, press → PAUSED; ball_out and 5 frame_pulses ignored; press → PLAY with lives/speed unchanged.
- Same-cycle ball_out and paddle_hit → lives decremented, hit count unchanged; rst asserted in SERVE → IDLE, all outputs at reset values.
